// File: rtl/gtech_arb_pkg.sv
// ---------------------------------------------------------------------------
// gtech_arb_pkg
// Shared definitions for the 4-way round-robin arbiter slice.
//   NREQ        : number of requesters
//   ID_W        : width of a requester index
//   CNT_W       : width of the optional hold (timeout) counter
//   arb_state_e : arbiter state (IDLE = no owner, GRANT = one owner)
// ---------------------------------------------------------------------------
package gtech_arb_pkg;

  localparam int NREQ  = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/gtech_rr_pick.sv
// ---------------------------------------------------------------------------
// gtech_rr_pick
// Purely combinational round-robin winner selection. Starting at the rotating
// pointer and wrapping 3 -> 0, the first request not masked by the exclude
// vector wins.
// Ports:
//   i_req   [NREQ-1:0] : request vector
//   i_ptr   [ID_W-1:0] : rotating priority pointer (highest priority index)
//   i_excl  [NREQ-1:0] : requests to ignore this cycle
//   o_gnt   [NREQ-1:0] : one-hot winner (zero when nothing eligible)
//   o_id    [ID_W-1:0] : binary index of the winner (zero when invalid)
//   o_valid            : a winner exists
// ---------------------------------------------------------------------------
module gtech_rr_pick
  import gtech_arb_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  input  logic [NREQ-1:0] i_excl,
  output logic [NREQ-1:0] o_gnt,
  output logic [ID_W-1:0] o_id,
  output logic            o_valid
);

  logic [NREQ-1:0] w_cand;

  assign w_cand = i_req & ~i_excl;

  // Walk the offsets from farthest to nearest so the candidate closest to the
  // pointer is the last one written and therefore wins; no priority chain
  // needs to read back its own outputs.
  always_comb begin
    logic [ID_W-1:0] w_idx;
    w_idx   = '0;
    o_gnt   = '0;
    o_id    = '0;
    o_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = i_ptr + ID_W'(k);
      if (w_cand[w_idx]) begin
        o_gnt   = NREQ'(1) << w_idx;
        o_id    = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gtech_rr_arb4.sv
// ---------------------------------------------------------------------------
// gtech_rr_arb4
// Four-requester round-robin arbiter for a single shared resource. A grant is
// registered one cycle after the request is seen, held until the owner drops
// its request or strobes its release, and then handed straight to the next
// round-robin winner with no idle cycle.
//
// Optional feature (macro GTECH_ARB_TIMEOUT_EN): a 4-bit hold counter limits
// any grant to MAX_HOLD cycles. When the limit is hit the owner is forced off
// (skipped if anyone else is waiting, otherwise re-granted with a fresh count)
// and TOUT pulses for one cycle. Without the macro TOUT is tied low and
// MAX_HOLD has no effect.
//
// Parameters:
//   MAX_HOLD : maximum grant length in cycles with the timeout built in (1..15)
// Ports:
//   CLK        : clock, all state changes on the rising edge
//   RST        : synchronous active-high reset
//   REQ  [3:0] : per-requester request
//   REL  [3:0] : per-requester release strobe (only the owner's bit matters)
//   GNT  [3:0] : registered one-hot grant, zero when idle
//   GNT_ID[1:0]: index of the current owner, zero when idle
//   BUSY       : a grant is held
//   TOUT       : one-cycle pulse on a forced release
// ---------------------------------------------------------------------------
module gtech_rr_arb4
  import gtech_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] REL,
  output logic [NREQ-1:0] GNT,
  output logic [ID_W-1:0] GNT_ID,
  output logic            BUSY,
  output logic            TOUT
);

  arb_state_e      r_state;
  logic [NREQ-1:0] r_gnt;
  logic [ID_W-1:0] r_id;
  logic [ID_W-1:0] r_ptr;

  arb_state_e      w_nxt_state;
  logic [NREQ-1:0] w_nxt_gnt;
  logic [ID_W-1:0] w_nxt_id;
  logic [ID_W-1:0] w_nxt_ptr;
  logic            w_new_grant;

  logic            w_owner_req;
  logic            w_owner_rel;
  logic            w_release;
  logic            w_timeout;
  logic [NREQ-1:0] w_excl;

  logic [NREQ-1:0] w_pick_gnt;
  logic [ID_W-1:0] w_pick_id;
  logic            w_pick_valid;

  // A voluntary release: the owner no longer wants the resource or strobes
  // its own release bit. Release bits of anyone else never reach this term.
  assign w_owner_req = REQ[r_id];
  assign w_owner_rel = REL[r_id];
  assign w_release   = (r_state == GRANT) && (!w_owner_req || w_owner_rel);

  // While someone owns the resource, their request is masked so a handover
  // cannot pick the same requester again in the cycle it lets go.
  assign w_excl = (r_state == GRANT) ? r_gnt : '0;

  gtech_rr_pick u_pick (
    .i_req   (REQ),
    .i_ptr   (r_ptr),
    .i_excl  (w_excl),
    .o_gnt   (w_pick_gnt),
    .o_id    (w_pick_id),
    .o_valid (w_pick_valid)
  );

`ifdef GTECH_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tout;

  // The counter holds the number of grant cycles already completed, so the
  // edge that closes the MAX_HOLD-th cycle sees HOLD_LAST. A voluntary
  // release on that same edge wins and is not reported as a timeout.
  assign w_timeout = (r_state == GRANT) && !w_release && (r_cnt == HOLD_LAST);

  // Every new grant (including a timeout re-grant) restarts the count; the
  // count only advances while a grant is being held.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt  <= '0;
      r_tout <= 1'b0;
    end else begin
      r_tout <= w_timeout;
      if (w_new_grant) begin
        r_cnt <= '0;
      end else if (r_state == GRANT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign TOUT = r_tout;
`else
  logic w_unused_max_hold;

  assign w_timeout         = 1'b0;
  assign w_unused_max_hold = ^CNT_W'(MAX_HOLD);
  assign TOUT              = 1'b0;
`endif

  // Next-state decision. A new grant always moves the pointer one past the
  // winner, so the winner becomes lowest priority for the following round.
  // A forced release with nobody else waiting hands the grant back to the
  // same owner and counts as a fresh grant.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_gnt   = r_gnt;
    w_nxt_id    = r_id;
    w_nxt_ptr   = r_ptr;
    w_new_grant = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_nxt_state = GRANT;
          w_nxt_gnt   = w_pick_gnt;
          w_nxt_id    = w_pick_id;
          w_nxt_ptr   = w_pick_id + ID_W'(1);
          w_new_grant = 1'b1;
        end
      end
      GRANT: begin
        if (w_release || w_timeout) begin
          if (w_pick_valid) begin
            w_nxt_gnt   = w_pick_gnt;
            w_nxt_id    = w_pick_id;
            w_nxt_ptr   = w_pick_id + ID_W'(1);
            w_new_grant = 1'b1;
          end else if (w_timeout) begin
            w_nxt_ptr   = r_id + ID_W'(1);
            w_new_grant = 1'b1;
          end else begin
            w_nxt_state = IDLE;
            w_nxt_gnt   = '0;
            w_nxt_id    = '0;
          end
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_gnt   = '0;
        w_nxt_id    = '0;
      end
    endcase
  end

  // State, grant and pointer registers. Reset drops any grant immediately
  // and restarts arbitration from requester 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_gnt   <= w_nxt_gnt;
      r_id    <= w_nxt_id;
      r_ptr   <= w_nxt_ptr;
    end
  end

  assign GNT    = r_gnt;
  assign GNT_ID = r_id;
  assign BUSY   = |r_gnt;

endmodule

// File: tb/tb_gtech_rr_arb4.sv
// ---------------------------------------------------------------------------
// tb_gtech_rr_arb4
// Self-checking bench for gtech_rr_arb4: directed scenarios with expected
// values written out by hand, then a long randomized run compared cycle by
// cycle against a behavioural model of the arbitration rules (owner index,
// priority pointer and hold count as plain integers).
// Honors GTECH_ARB_TIMEOUT_EN: with it the DUT is built with MAX_HOLD = 3.
// ---------------------------------------------------------------------------
module tb_gtech_rr_arb4;

`ifdef GTECH_ARB_TIMEOUT_EN
  localparam int HOLD  = 3;
  localparam bit TO_EN = 1'b1;
`else
  localparam int HOLD  = 15;
  localparam bit TO_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] REQ = '0;
  logic [3:0] REL = '0;
  logic [3:0] GNT;
  logic [1:0] GNT_ID;
  logic       BUSY;
  logic       TOUT;
  logic [7:0] dutVec;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state: owner index (-1 = idle), pointer, hold cycles done.
  int mOwner = -1;
  int mPtr   = 0;
  int mHold  = 0;
  bit mTout  = 1'b0;

  gtech_rr_arb4 #(.MAX_HOLD(HOLD)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .REQ    (REQ),
    .REL    (REL),
    .GNT    (GNT),
    .GNT_ID (GNT_ID),
    .BUSY   (BUSY),
    .TOUT   (TOUT)
  );

  always #5 CLK = ~CLK;

  assign dutVec = {GNT, GNT_ID, BUSY, TOUT};

  // First requester at or after the pointer, wrapping, other than 'skip'.
  function automatic int rrPick(input logic [3:0] req, input int skip, input int ptr);
    int c;
    for (int k = 0; k < 4; k++) begin
      c = (ptr + k) % 4;
      if (req[c] && c != skip) return c;
    end
    return -1;
  endfunction

  // One clock edge of the arbitration rules, applied to the model.
  task automatic modelStep(input logic [3:0] req, input logic [3:0] rel, input logic rst);
    int w;
    bit relNow;
    bit forced;
    if (rst) begin
      mOwner = -1; mPtr = 0; mHold = 0; mTout = 1'b0;
    end else if (mOwner < 0) begin
      mTout = 1'b0;
      w = rrPick(req, -1, mPtr);
      if (w >= 0) begin
        mOwner = w; mPtr = (w + 1) % 4; mHold = 0;
      end
    end else begin
      relNow = !req[mOwner] || rel[mOwner];
      forced = TO_EN && !relNow && (mHold + 1 >= HOLD);
      mTout  = forced;
      if (relNow || forced) begin
        w = rrPick(req, mOwner, mPtr);
        if (w >= 0) begin
          mOwner = w; mPtr = (w + 1) % 4; mHold = 0;
        end else if (forced) begin
          mPtr = (mOwner + 1) % 4; mHold = 0;
        end else begin
          mOwner = -1;
        end
      end else begin
        mHold++;
      end
    end
  endtask

  function automatic logic [7:0] modelVec();
    if (mOwner < 0) return 8'h00;
    return {4'(1 << mOwner), 2'(mOwner), 1'b1, mTout};
  endfunction

  // Drive one cycle of inputs, advance the model, sample just after the edge.
  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] rel, input logic rst);
    REQ = req;
    REL = rel;
    RST = rst;
    modelStep(req, rel, rst);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(4'b1111, 4'b1111, 1'b1);
      nChecks++;
      if (dutVec !== 8'h00) begin
        nFails++;
        $display("[TB] FAIL reset[%0d]: got %b expected %b", k, dutVec, 8'h00);
      end
    end
  endtask

  task automatic test_first_grant();
    logic [3:0] reqs [4] = '{4'b0001, 4'b0000, 4'b1001, 4'b0000};
    logic [7:0] exps [4] = '{{4'b0001, 2'd0, 1'b1, 1'b0}, 8'h00,
                             {4'b1000, 2'd3, 1'b1, 1'b0}, 8'h00};
    for (int k = 0; k < 4; k++) begin
      applyStimulus(reqs[k], 4'b0000, 1'b0);
      nChecks++;
      if (dutVec !== exps[k]) begin
        nFails++;
        $display("[TB] FAIL first_grant[%0d]: got %b expected %b", k, dutVec, exps[k]);
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] exp;
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) applyStimulus(4'b1111, order[k-1], 1'b0);
      exp = {order[k], 2'(k % 4), 1'b1, 1'b0};
      nChecks++;
      if (dutVec !== exp) begin
        nFails++;
        $display("[TB] FAIL rotation[%0d]: got %b expected %b", k, dutVec, exp);
      end
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    nChecks++;
    if (dutVec !== 8'h00) begin
      nFails++;
      $display("[TB] FAIL rotation_idle: got %b expected %b", dutVec, 8'h00);
    end
  endtask

  task automatic test_nonowner_rel();
    logic [3:0] reqs [4] = '{4'b0100, 4'b0101, 4'b0101, 4'b0000};
    logic [3:0] rels [4] = '{4'b0000, 4'b0001, 4'b1011, 4'b0000};
    logic [7:0] own = {4'b0100, 2'd2, 1'b1, 1'b0};
    logic [7:0] exps [4];
    exps = '{own, own, own, 8'h00};
    for (int k = 0; k < 4; k++) begin
      applyStimulus(reqs[k], rels[k], 1'b0);
      nChecks++;
      if (dutVec !== exps[k]) begin
        nFails++;
        $display("[TB] FAIL nonowner_rel[%0d]: got %b expected %b", k, dutVec, exps[k]);
      end
    end
  endtask

  task automatic test_reset_during_grant();
    logic [3:0] reqs [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b1001, 4'b0000};
    logic       rsts [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] g1 = {4'b0010, 2'd1, 1'b1, 1'b0};
    logic [7:0] g0 = {4'b0001, 2'd0, 1'b1, 1'b0};
    logic [7:0] exps [7];
    exps = '{g1, 8'h00, g1, 8'h00, 8'h00, g0, 8'h00};
    for (int k = 0; k < 7; k++) begin
      applyStimulus(reqs[k], 4'b0000, rsts[k]);
      nChecks++;
      if (dutVec !== exps[k]) begin
        nFails++;
        $display("[TB] FAIL reset_in_grant[%0d]: got %b expected %b", k, dutVec, exps[k]);
      end
    end
  endtask

`ifdef GTECH_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] o0  = {4'b0001, 2'd0, 1'b1, 1'b0};
    logic [7:0] o0t = {4'b0001, 2'd0, 1'b1, 1'b1};
    logic [7:0] o1  = {4'b0010, 2'd1, 1'b1, 1'b0};
    logic [7:0] o1t = {4'b0010, 2'd1, 1'b1, 1'b1};
    logic [3:0] reqs [12] = '{4'b0000, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
                              4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    logic       rsts [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] exps [12];
    exps = '{8'h00, o0, o0, o0, o1t, o1, 8'h00, o0, o0, o0, o0t, o0};
    for (int k = 0; k < 12; k++) begin
      applyStimulus(reqs[k], 4'b0000, rsts[k]);
      nChecks++;
      if (dutVec !== exps[k]) begin
        nFails++;
        $display("[TB] FAIL timeout[%0d]: got %b expected %b", k, dutVec, exps[k]);
      end
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0);
  endtask
`else
  task automatic test_no_timeout();
    logic [7:0] o0 = {4'b0001, 2'd0, 1'b1, 1'b0};
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(4'b0001, 4'b0000, 1'b0);
      nChecks++;
      if (dutVec !== o0) begin
        nFails++;
        $display("[TB] FAIL long_hold[%0d]: got %b expected %b", k, dutVec, o0);
      end
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0);
  endtask
`endif

  task automatic test_random();
    logic [3:0] req;
    logic [3:0] rel;
    logic       rst;
    logic [3:0] prevGnt;
    logic [7:0] exp;
    int         waitCnt [4];
    req = '0;
    prevGnt = '0;
    for (int i = 0; i < 4; i++) waitCnt[i] = 0;
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
        rel[i] = ($urandom_range(0, 3) == 0);
      end
      rst = ($urandom_range(0, 999) == 0);
      applyStimulus(req, rel, rst);
      exp = modelVec();
      nChecks++;
      if (dutVec !== exp) begin
        nFails++;
        $display("[TB] FAIL random_cycle[%0d]: got %b expected %b req=%b rel=%b rst=%b",
                 n, dutVec, exp, req, rel, rst);
      end
      nChecks++;
      if ($countones(GNT) > 1) begin
        nFails++;
        $display("[TB] FAIL onehot[%0d]: got GNT=%b expected at most one bit", n, GNT);
      end
      if (rst) begin
        for (int i = 0; i < 4; i++) waitCnt[i] = 0;
      end else if (GNT != 4'b0000 && GNT != prevGnt) begin
        for (int i = 0; i < 4; i++) begin
          if (GNT[i] || !req[i]) waitCnt[i] = 0;
          else waitCnt[i]++;
          nChecks++;
          if (waitCnt[i] > 3) begin
            nFails++;
            $display("[TB] FAIL starvation[%0d]: requester %0d waited %0d grants, limit 3",
                     n, i, waitCnt[i]);
          end
        end
      end else begin
        for (int i = 0; i < 4; i++) if (!req[i]) waitCnt[i] = 0;
      end
      prevGnt = GNT;
    end
  endtask

  initial begin
    $display("[TB] gtech_rr_arb4 bench, timeout build=%0d, MAX_HOLD=%0d", TO_EN, HOLD);
    test_reset();
    test_first_grant();
    test_rotation();
    test_nonowner_rel();
    test_reset_during_grant();
`ifdef GTECH_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/gtech_rr_arb4.md
GTECH_RR_ARB4 -- requirements
Module: gtech_rr_arb4

Interface
REQ-001: SHALL have parameter MAX_HOLD, default 15, maximum grant length in cycles when the timeout is compiled in (range 1..15).
REQ-002: SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003: SHALL have port RST, input, 1, reset; synchronous, active-high.
REQ-004: SHALL have port REQ, input, 4, per-requester access request for the shared resource.
REQ-005: SHALL have port REL, input, 4, per-requester release strobe.
REQ-006: SHALL have port GNT, output, 4, one-hot grant (all zero when idle).
REQ-007: SHALL have port GNT_ID, output, 2, binary index of the current owner; value is 0 when BUSY=0.
REQ-008: SHALL have port BUSY, output, 1, high while any grant is held.
REQ-009: SHALL have port TOUT, output, 1, one-cycle pulse on a forced release.

Function
REQ-010: SHALL implement two states: IDLE (no owner) and GRANT (one owner).
REQ-011: IDLE -> GRANT when any REQ bit is 1; GNT is registered and asserts one cycle after REQ is sampled.
REQ-012: Winner SHALL be chosen round-robin: the lowest index at or above rotating pointer PTR, wrapping 3 -> 0.
REQ-013: On every new grant, PTR SHALL become (winner + 1) mod 4.
REQ-014: In GRANT, the owner SHALL hold while REQ[owner]=1 and REL[owner]=0.
REQ-015: Release SHALL occur when REL[owner]=1 or REQ[owner]=0; the grant then ends at the next edge.
REQ-016: At release, if any other REQ bit is 1, the arbiter SHALL grant the next round-robin winner at the same edge, with no idle cycle; otherwise it SHALL go to IDLE.
REQ-017: When choosing the next winner at release, the releasing owner's REQ SHALL be ignored for that cycle.
REQ-018: REL bits of non-owners SHALL be ignored, and REL in IDLE SHALL be ignored.
REQ-019: GNT SHALL never have more than one bit set.
REQ-020: BUSY SHALL equal the OR of GNT, and GNT_ID SHALL equal the encoding of GNT.

Reset
REQ-021: While RST=1 at an edge, the arbiter SHALL set GNT=0, GNT_ID=0, BUSY=0, TOUT=0, PTR=0, hold counter=0, and state=IDLE.
REQ-022: Reset applied during GRANT SHALL drop the grant at that edge, with no TOUT pulse.
REQ-023: Arbitration SHALL resume on the first edge with RST=0.

Configuration
REQ-024: Macro GTECH_ARB_TIMEOUT_EN SHALL compile in a 4-bit hold counter.
  - The counter clears on every new grant.
  - It increments each cycle in GRANT.
  - When it reaches MAX_HOLD, release is forced and TOUT pulses for 1 cycle.
REQ-025: On a forced release, the owner SHALL be skipped if any other REQ bit is set; otherwise the owner SHALL be re-granted with the counter cleared.
REQ-026: Without GTECH_ARB_TIMEOUT_EN, no counter SHALL exist, TOUT SHALL be tied to 0, and MAX_HOLD SHALL be unused.

Structure
REQ-027: Shared package gtech_arb_pkg SHALL hold:
  - the state enum (IDLE, GRANT);
  - constant NREQ=4;
  - constant ID_W=2;
  - the hold-counter width constant.
REQ-028: Combinational sub-module gtech_rr_pick SHALL take request vector, pointer and exclude mask, and return a one-hot winner, its index and a valid flag.

Verification
REQ-029: Reset, then REQ=0001 -> GNT=0001, GNT_ID=0, BUSY=1 one cycle later; PTR=1.
REQ-030: REQ=1111 held, each owner pulses REL one cycle after its grant -> grants in order 0001, 0010, 0100, 1000, 0001, with no idle gaps.
REQ-031: Owner 2 holding, REQ=0101, REL=0001 (non-owner) -> grant unchanged, GNT=0100.
REQ-032: RST=1 while GNT=0010 -> next edge GNT=0000, BUSY=0, TOUT=0; then REQ=0010 -> grant to 1 from PTR=0.
REQ-033: With GTECH_ARB_TIMEOUT_EN and MAX_HOLD=3:
  - REQ=0011, owner 0 never releases -> TOUT pulses after 3 grant cycles and GNT=0010.
  - REQ=0001 alone -> TOUT pulses and owner 0 is re-granted.
REQ-034: Random REQ/REL for 10k cycles -> GNT is one-hot-or-zero every cycle and no requester is starved beyond 3 other grants.
